// File: rtl/axi_mst_wdata_gen_if.sv
// Bus bundle for the W-data generator: observed AW, generated W, B/R ready, status.
// Latency: none, wires only.
// Backpressure: none here; master = generator side, slave = environment side.
interface axi_mst_wdata_gen_if #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32
);
    localparam int NB   = AXI_DATA_W / 8;
    localparam int LO_W = (NB > 1) ? $clog2(NB) : 1;

    logic                  in_awvalid;
    logic                  in_awready;
    logic [AXI_ID_W-1:0]   in_awid;
    logic [7:0]            in_awlen;
    logic [2:0]            in_awsize;
    logic [LO_W-1:0]       in_awaddr_lo;
    logic                  out_wvalid;
    logic                  out_wlast;
    logic                  in_wready;
    logic [AXI_ID_W-1:0]   out_wid;
    logic [AXI_DATA_W-1:0] out_wdata;
    logic [NB-1:0]         out_wstrb;
    logic                  in_bvalid;
    logic [AXI_ID_W-1:0]   in_bid;
    logic                  out_bready;
    logic                  out_rready;
    logic [1:0]            in_rdy_mode;
    logic                  out_q_full;
    logic [7:0]            out_b_pend;
    logic [2:0]            out_err;

    modport master (
        input  in_awvalid, in_awready, in_awid, in_awlen, in_awsize, in_awaddr_lo,
        input  in_wready, in_bvalid, in_bid, in_rdy_mode,
        output out_wvalid, out_wlast, out_wid, out_wdata, out_wstrb,
        output out_bready, out_rready, out_q_full, out_b_pend, out_err
    );

    modport slave (
        output in_awvalid, in_awready, in_awid, in_awlen, in_awsize, in_awaddr_lo,
        output in_wready, in_bvalid, in_bid, in_rdy_mode,
        input  out_wvalid, out_wlast, out_wid, out_wdata, out_wstrb,
        input  out_bready, out_rready, out_q_full, out_b_pend, out_err
    );
endinterface

// File: rtl/axi_mst_wdata_gen.sv
// Generates AXI W bursts (LFSR data, lane-accurate strobes) for AW requests it observes.
// Latency: first W beat valid one cycle after the AW handshake; one beat per cycle after.
// Backpressure: W outputs hold while in_wready is low; a push into a full queue is dropped.
module axi_mst_wdata_gen #(
    parameter int          AXI_ID_W        = 4,
    parameter int          AXI_DATA_W      = 32,
    parameter int          MST_OSTDREQ_NUM = 4,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_2345
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                srst,
    axi_mst_wdata_gen_if.master bus
);
    localparam int          NB        = AXI_DATA_W / 8;
    localparam int          SZ_MAX    = $clog2(NB);
    localparam int          LO_W      = (NB > 1) ? $clog2(NB) : 1;
    localparam int          PW        = $clog2(MST_OSTDREQ_NUM);
    localparam int          CW        = PW + 1;
    localparam logic [2:0]  SZ_MAX3   = 3'(SZ_MAX);
    localparam logic [CW-1:0] DEPTH   = CW'(MST_OSTDREQ_NUM);
    localparam logic [15:0] NB_MASK   = 16'(NB - 1);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Request queue storage and control state
    logic [AXI_ID_W-1:0] q_id_q   [MST_OSTDREQ_NUM];
    logic [AXI_ID_W-1:0] q_id_d   [MST_OSTDREQ_NUM];
    logic [7:0]          q_len_q  [MST_OSTDREQ_NUM];
    logic [7:0]          q_len_d  [MST_OSTDREQ_NUM];
    logic [2:0]          q_size_q [MST_OSTDREQ_NUM];
    logic [2:0]          q_size_d [MST_OSTDREQ_NUM];
    logic [LO_W-1:0]     q_addr_q [MST_OSTDREQ_NUM];
    logic [LO_W-1:0]     q_addr_d [MST_OSTDREQ_NUM];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          beat_q, beat_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic                bready_q, bready_d, rready_q, rready_d;
    logic [7:0]          b_pend_q, b_pend_d;
    logic [2:0]          err_q, err_d;

    // Head view and beat-level decode
    logic [AXI_ID_W-1:0]   h_id;
    logic [7:0]            h_len;
    logic [2:0]            h_size;
    logic [LO_W-1:0]       h_addr;
    logic                  w_vld, w_last, w_hs, w_last_hs, aw_hs, b_hs, q_full, push_ok;
    logic [15:0]           bsz, a0, lane, lo, hi;
    logic [NB-1:0]         strb;
    logic [AXI_DATA_W-1:0] wdata;
    logic                  unused_bid;

    assign unused_bid = ^bus.in_bid;

    // Head-of-queue beat: lane window [lo..hi] and LFSR data masked by strobe
    always_comb begin
        h_id   = q_id_q[rd_ptr_q];
        h_len  = q_len_q[rd_ptr_q];
        h_size = q_size_q[rd_ptr_q];
        h_addr = q_addr_q[rd_ptr_q];
        w_vld  = (cnt_q != '0);
        w_last = w_vld && (beat_q == h_len);
        bsz    = 16'd1 << h_size;
        a0     = (16'(h_addr) & NB_MASK) & ~(bsz - 16'd1);
        lane   = (a0 + (16'(beat_q) << h_size)) & NB_MASK;
        lo     = (beat_q == 8'd0) ? (16'(h_addr) & NB_MASK) : lane;
        hi     = lane + bsz - 16'd1;
        strb   = '0;
        wdata  = '0;
        for (int i = 0; i < NB; i++) begin
            strb[i] = w_vld && (16'(i) >= lo) && (16'(i) <= hi);
            if (strb[i]) wdata[i*8 +: 8] = lfsr_q[(i % 4)*8 +: 8];
        end
    end

    assign aw_hs     = bus.in_awvalid && bus.in_awready;
    assign w_hs      = w_vld && bus.in_wready;
    assign w_last_hs = w_hs && w_last;
    assign b_hs      = bus.in_bvalid && bready_q;
    assign q_full    = (cnt_q == DEPTH);
    assign push_ok   = aw_hs && (!q_full || w_last_hs);

    // Next-state: queue push/pop, beat/LFSR advance, ready policy, B tracking, sync clear
    always_comb begin
        q_id_d   = q_id_q;
        q_len_d  = q_len_q;
        q_size_d = q_size_q;
        q_addr_d = q_addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        lfsr_d   = lfsr_q;
        bready_d = bready_q;
        rready_d = rready_q;
        b_pend_d = b_pend_q;
        err_d    = err_q;

        if (push_ok) begin
            q_id_d[wr_ptr_q]   = bus.in_awid;
            q_len_d[wr_ptr_q]  = bus.in_awlen;
            q_size_d[wr_ptr_q] = (bus.in_awsize > SZ_MAX3) ? SZ_MAX3 : bus.in_awsize;
            q_addr_d[wr_ptr_q] = bus.in_awaddr_lo;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end
        if (aw_hs && q_full && !w_last_hs) err_d[0] = 1'b1;
        if (aw_hs && (bus.in_awsize > SZ_MAX3)) err_d[1] = 1'b1;
        if (w_last_hs) rd_ptr_d = rd_ptr_q + PW'(1);

        if (push_ok && !w_last_hs)      cnt_d = cnt_q + CW'(1);
        else if (!push_ok && w_last_hs) cnt_d = cnt_q - CW'(1);

        if (w_hs) begin
            beat_d = w_last ? 8'd0 : beat_q + 8'd1;
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
        end

        case (bus.in_rdy_mode)
            2'b00: begin bready_d = 1'b1;      rready_d = 1'b1;      end
            2'b01: begin bready_d = lfsr_q[0]; rready_d = lfsr_q[1]; end
            2'b10: begin bready_d = 1'b0;      rready_d = 1'b0;      end
            default: begin bready_d = ~bready_q; rready_d = ~rready_q; end
        endcase

        if (w_last_hs && !b_hs) begin
            if (b_pend_q != 8'hFF) b_pend_d = b_pend_q + 8'd1;
        end else if (b_hs && !w_last_hs) begin
            if (b_pend_q == 8'd0) err_d[2] = 1'b1;
            else                  b_pend_d = b_pend_q - 8'd1;
        end

        if (srst) begin
            for (int i = 0; i < MST_OSTDREQ_NUM; i++) begin
                q_id_d[i] = '0; q_len_d[i] = '0; q_size_d[i] = '0; q_addr_d[i] = '0;
            end
            wr_ptr_d = '0; rd_ptr_d = '0; cnt_d = '0; beat_d = '0;
            lfsr_d   = LFSR_SEED;
            bready_d = 1'b0; rready_d = 1'b0; b_pend_d = '0; err_d = '0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < MST_OSTDREQ_NUM; i++) begin
                q_id_q[i] <= '0; q_len_q[i] <= '0; q_size_q[i] <= '0; q_addr_q[i] <= '0;
            end
            wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0; beat_q <= '0;
            lfsr_q   <= LFSR_SEED;
            bready_q <= 1'b0; rready_q <= 1'b0; b_pend_q <= '0; err_q <= '0;
        end else begin
            q_id_q   <= q_id_d;   q_len_q  <= q_len_d;
            q_size_q <= q_size_d; q_addr_q <= q_addr_d;
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; cnt_q <= cnt_d; beat_q <= beat_d;
            lfsr_q   <= lfsr_d;
            bready_q <= bready_d; rready_q <= rready_d; b_pend_q <= b_pend_d; err_q <= err_d;
        end
    end

    assign bus.out_wvalid = w_vld;
    assign bus.out_wlast  = w_last;
    assign bus.out_wid    = w_vld ? h_id : '0;
    assign bus.out_wdata  = wdata;
    assign bus.out_wstrb  = strb;
    assign bus.out_bready = bready_q;
    assign bus.out_rready = rready_q;
    assign bus.out_q_full = q_full;
    assign bus.out_b_pend = b_pend_q;
    assign bus.out_err    = err_q;
endmodule

// File: tb/tb_axi_mst_wdata_gen.sv
// Directed bench for axi_mst_wdata_gen (ID 4, data 32, queue depth 4).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: driven through in_wready (fixed and random).
module tb_axi_mst_wdata_gen;
    localparam logic [31:0] SEED = 32'hACE1_2345;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic srst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] model;

    axi_mst_wdata_gen_if #(.AXI_ID_W(4), .AXI_DATA_W(32)) bus ();

    axi_mst_wdata_gen #(.AXI_ID_W(4), .AXI_DATA_W(32), .MST_OSTDREQ_NUM(4), .LFSR_SEED(SEED)) dut (
        .aclk(aclk), .areset(areset), .srst(srst), .bus(bus)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] s, input logic [3:0] st);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) if (st[i]) d[i*8 +: 8] = s[i*8 +: 8];
        return d;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_awvalid = 0; bus.in_awready = 0; bus.in_awid = 0; bus.in_awlen = 0;
        bus.in_awsize = 0; bus.in_awaddr_lo = 0; bus.in_wready = 0; bus.in_bvalid = 0;
        bus.in_bid = 0; bus.in_rdy_mode = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        srst = 0;
        areset = 1;
        #2;
        areset = 0;
        model = SEED;
        tick();
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] addr);
        bus.in_awid = id; bus.in_awlen = len; bus.in_awsize = size; bus.in_awaddr_lo = addr;
        bus.in_awvalid = 1; bus.in_awready = 1;
        tick();
        bus.in_awvalid = 0; bus.in_awready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        n_chk++;
        if ({bus.out_wvalid, bus.out_wlast, bus.out_wid, bus.out_wstrb, bus.out_wdata} !== 42'd0) begin
            n_fail++; $display("FAIL reset_w_outputs: got %h want 0",
                {bus.out_wvalid, bus.out_wlast, bus.out_wid, bus.out_wstrb, bus.out_wdata});
        end
        n_chk++;
        if ({bus.out_bready, bus.out_rready, bus.out_q_full, bus.out_b_pend, bus.out_err} !== 14'd0) begin
            n_fail++; $display("FAIL reset_status: got %h want 0",
                {bus.out_bready, bus.out_rready, bus.out_q_full, bus.out_b_pend, bus.out_err});
        end
        areset = 0;
        model = SEED;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        send_aw(4'd5, 8'd3, 3'd2, 2'd0);
        bus.in_wready = 1;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if ({bus.out_wvalid, bus.out_wlast, bus.out_wid, bus.out_wstrb, bus.out_wdata} !==
                {1'b1, 1'(k == 3), 4'd5, 4'hF, exp_data(model, 4'hF)}) begin
                n_fail++; $display("FAIL single_beat%0d: got v%b l%b id%h s%b d%h want l%b d%h", k,
                    bus.out_wvalid, bus.out_wlast, bus.out_wid, bus.out_wstrb, bus.out_wdata,
                    1'(k == 3), exp_data(model, 4'hF));
            end
            model = lfsr_next(model);
            tick();
        end
        bus.in_wready = 0;
        n_chk++;
        if ({bus.out_wvalid, bus.out_b_pend} !== {1'b0, 8'd1}) begin
            n_fail++; $display("FAIL single_after: got wvalid %b b_pend %0d want 0 1",
                bus.out_wvalid, bus.out_b_pend);
        end
        bus.in_bvalid = 1;
        tick();
        bus.in_bvalid = 0;
        n_chk++;
        if ({bus.out_b_pend, bus.out_err} !== 11'd0) begin
            n_fail++; $display("FAIL single_b: got b_pend %0d err %b want 0 000", bus.out_b_pend, bus.out_err);
        end
    endtask

    task automatic test_narrow();
        logic [3:0] st_tab [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        send_aw(4'd6, 8'd3, 3'd0, 2'd2);
        bus.in_wready = 1;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if ({bus.out_wlast, bus.out_wstrb, bus.out_wdata} !==
                {1'(k == 3), st_tab[k], exp_data(model, st_tab[k])}) begin
                n_fail++; $display("FAIL narrow_beat%0d: got l%b s%b d%h want l%b s%b d%h", k,
                    bus.out_wlast, bus.out_wstrb, bus.out_wdata, 1'(k == 3), st_tab[k],
                    exp_data(model, st_tab[k]));
            end
            model = lfsr_next(model);
            tick();
        end
        bus.in_wready = 0;
    endtask

    task automatic test_backpressure();
        logic [41:0] cur, prev;
        logic stalled, wr, done;
        int beats;
        do_reset();
        send_aw(4'd7, 8'd7, 3'd2, 2'd0);
        stalled = 0; done = 0; beats = 0; prev = '0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            cur = {bus.out_wvalid, bus.out_wlast, bus.out_wid, bus.out_wstrb, bus.out_wdata};
            if (stalled) begin
                n_chk++;
                if (cur !== prev) begin
                    n_fail++; $display("FAIL bp_stable cyc%0d: got %h want %h", cyc, cur, prev);
                end
            end
            n_chk++;
            if (cur !== {1'b1, 1'(beats == 7), 4'd7, 4'hF, exp_data(model, 4'hF)}) begin
                n_fail++; $display("FAIL bp_beat%0d: got %h want data %h last %b", beats, cur,
                    exp_data(model, 4'hF), 1'(beats == 7));
            end
            wr = 1'($urandom_range(0, 1));
            bus.in_wready = wr;
            stalled = !wr;
            prev = cur;
            if (wr) begin
                model = lfsr_next(model);
                beats++;
                if (beats == 8) done = 1;
            end
            tick();
        end
        bus.in_wready = 0;
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL bp_timeout: got %0d beats want 8", beats);
        end
    endtask

    task automatic test_queue();
        logic [3:0] exp_ids [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        int idx;
        do_reset();
        for (int i = 0; i < 4; i++) send_aw(exp_ids[i], 8'd0, 3'd2, 2'd0);
        n_chk++;
        if ({bus.out_q_full, bus.out_err} !== 4'b1000) begin
            n_fail++; $display("FAIL queue_full4: got full %b err %b want 1 000", bus.out_q_full, bus.out_err);
        end
        send_aw(4'd9, 8'd0, 3'd2, 2'd0);
        n_chk++;
        if ({bus.out_q_full, bus.out_err} !== 4'b1001) begin
            n_fail++; $display("FAIL queue_overflow: got full %b err %b want 1 001", bus.out_q_full, bus.out_err);
        end
        bus.in_wready = 1;
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            if (bus.out_wvalid) begin
                n_chk++;
                if ({bus.out_wid, bus.out_wlast} !== {exp_ids[idx], 1'b1}) begin
                    n_fail++; $display("FAIL queue_order%0d: got id %0d last %b want id %0d last 1", idx,
                        bus.out_wid, bus.out_wlast, exp_ids[idx]);
                end
                idx++;
                model = lfsr_next(model);
            end
            tick();
        end
        bus.in_wready = 0;
        n_chk++;
        if (idx != 4 || bus.out_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL queue_drain: got %0d bursts wvalid %b want 4 0", idx, bus.out_wvalid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp_ids [4] = '{4'd2, 4'd3, 4'd4, 4'd7};
        int idx;
        do_reset();
        for (int i = 1; i <= 4; i++) send_aw(4'(i), 8'd1, 3'd2, 2'd0);
        bus.in_wready = 1;
        model = lfsr_next(model);
        tick();
        n_chk++;
        if ({bus.out_wid, bus.out_wlast, bus.out_q_full} !== {4'd1, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL fpp_pop_beat: got id %0d last %b full %b want 1 1 1",
                bus.out_wid, bus.out_wlast, bus.out_q_full);
        end
        model = lfsr_next(model);
        send_aw(4'd7, 8'd1, 3'd2, 2'd0);
        n_chk++;
        if ({bus.out_q_full, bus.out_err} !== 4'b1000) begin
            n_fail++; $display("FAIL fpp_push_accept: got full %b err %b want 1 000", bus.out_q_full, bus.out_err);
        end
        idx = 0;
        for (int cyc = 0; cyc < 30 && idx < 4; cyc++) begin
            if (bus.out_wvalid && bus.out_wlast) begin
                n_chk++;
                if (bus.out_wid !== exp_ids[idx]) begin
                    n_fail++; $display("FAIL fpp_order%0d: got id %0d want %0d", idx, bus.out_wid, exp_ids[idx]);
                end
                idx++;
            end
            tick();
        end
        bus.in_wready = 0;
        n_chk++;
        if (idx != 4) begin
            n_fail++; $display("FAIL fpp_drain: got %0d bursts want 4", idx);
        end
    endtask

    task automatic test_long_burst();
        do_reset();
        send_aw(4'd2, 8'd255, 3'd2, 2'd0);
        bus.in_wready = 1;
        for (int k = 0; k < 256; k++) begin
            n_chk++;
            if ({bus.out_wvalid, bus.out_wlast, bus.out_wdata} !== {1'b1, 1'(k == 255), model}) begin
                n_fail++; $display("FAIL long_beat%0d: got v%b l%b d%h want v1 l%b d%h", k,
                    bus.out_wvalid, bus.out_wlast, bus.out_wdata, 1'(k == 255), model);
            end
            model = lfsr_next(model);
            tick();
        end
        bus.in_wready = 0;
        n_chk++;
        if ({bus.out_wvalid, bus.out_b_pend} !== {1'b0, 8'd1}) begin
            n_fail++; $display("FAIL long_after: got wvalid %b b_pend %0d want 0 1", bus.out_wvalid, bus.out_b_pend);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_aw(4'd1, 8'd7, 3'd2, 2'd0);
        bus.in_wready = 1;
        for (int k = 0; k < 3; k++) tick();
        #2;
        areset = 1;
        #1;
        n_chk++;
        if ({bus.out_wvalid, bus.out_wlast, bus.out_wid, bus.out_wstrb, bus.out_wdata,
             bus.out_bready, bus.out_rready, bus.out_q_full, bus.out_b_pend, bus.out_err} !== 56'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got w %h st %h want 0",
                {bus.out_wvalid, bus.out_wlast, bus.out_wid, bus.out_wstrb, bus.out_wdata},
                {bus.out_bready, bus.out_rready, bus.out_q_full, bus.out_b_pend, bus.out_err});
        end
        areset = 0;
        model = SEED;
        tick();
        send_aw(4'd3, 8'd1, 3'd2, 2'd0);
        n_chk++;
        if ({bus.out_wid, bus.out_wlast, bus.out_wdata} !== {4'd3, 1'b0, SEED}) begin
            n_fail++; $display("FAIL midrst_beat0: got id %0d l%b d%h want 3 0 %h",
                bus.out_wid, bus.out_wlast, bus.out_wdata, SEED);
        end
        tick();
        n_chk++;
        if ({bus.out_wlast, bus.out_wdata} !== {1'b1, lfsr_next(SEED)}) begin
            n_fail++; $display("FAIL midrst_beat1: got l%b d%h want 1 %h", bus.out_wlast, bus.out_wdata,
                lfsr_next(SEED));
        end
        tick();
        bus.in_wready = 0;
    endtask

    task automatic test_errors();
        do_reset();
        send_aw(4'd1, 8'd0, 3'd3, 2'd0);
        n_chk++;
        if ({bus.out_err, bus.out_wstrb, bus.out_wlast} !== {3'b010, 4'hF, 1'b1}) begin
            n_fail++; $display("FAIL err_size: got err %b strb %b last %b want 010 1111 1",
                bus.out_err, bus.out_wstrb, bus.out_wlast);
        end
        bus.in_wready = 1;
        tick();
        bus.in_wready = 0;
        bus.in_bvalid = 1;
        tick();
        n_chk++;
        if ({bus.out_err, bus.out_b_pend} !== {3'b010, 8'd0}) begin
            n_fail++; $display("FAIL err_b_ok: got err %b b_pend %0d want 010 0", bus.out_err, bus.out_b_pend);
        end
        tick();
        bus.in_bvalid = 0;
        n_chk++;
        if ({bus.out_err, bus.out_b_pend} !== {3'b110, 8'd0}) begin
            n_fail++; $display("FAIL err_unexp_b: got err %b b_pend %0d want 110 0", bus.out_err, bus.out_b_pend);
        end
    endtask

    task automatic test_rdy_mode();
        do_reset();
        n_chk++;
        if ({bus.out_bready, bus.out_rready} !== 2'b11) begin
            n_fail++; $display("FAIL rdy_mode00: got %b want 11", {bus.out_bready, bus.out_rready});
        end
        bus.in_rdy_mode = 2'b10;
        tick();
        n_chk++;
        if ({bus.out_bready, bus.out_rready} !== 2'b00) begin
            n_fail++; $display("FAIL rdy_mode10: got %b want 00", {bus.out_bready, bus.out_rready});
        end
        bus.in_rdy_mode = 2'b11;
        tick();
        n_chk++;
        if ({bus.out_bready, bus.out_rready} !== 2'b11) begin
            n_fail++; $display("FAIL rdy_toggle1: got %b want 11", {bus.out_bready, bus.out_rready});
        end
        tick();
        n_chk++;
        if ({bus.out_bready, bus.out_rready} !== 2'b00) begin
            n_fail++; $display("FAIL rdy_toggle2: got %b want 00", {bus.out_bready, bus.out_rready});
        end
        bus.in_rdy_mode = 2'b01;
        tick();
        n_chk++;
        if ({bus.out_bready, bus.out_rready} !== {model[0], model[1]}) begin
            n_fail++; $display("FAIL rdy_lfsr: got %b want %b", {bus.out_bready, bus.out_rready},
                {model[0], model[1]});
        end
        bus.in_rdy_mode = 2'b00;
    endtask

    task automatic test_srst();
        do_reset();
        send_aw(4'd4, 8'd2, 3'd2, 2'd0);
        bus.in_wready = 1;
        tick();
        bus.in_wready = 0;
        srst = 1;
        tick();
        srst = 0;
        n_chk++;
        if ({bus.out_wvalid, bus.out_q_full, bus.out_bready, bus.out_b_pend} !== 11'd0) begin
            n_fail++; $display("FAIL srst_clear: got wvalid %b full %b bready %b b_pend %0d want 0",
                bus.out_wvalid, bus.out_q_full, bus.out_bready, bus.out_b_pend);
        end
        model = SEED;
        send_aw(4'd8, 8'd0, 3'd2, 2'd0);
        n_chk++;
        if ({bus.out_wid, bus.out_wlast, bus.out_wdata} !== {4'd8, 1'b1, SEED}) begin
            n_fail++; $display("FAIL srst_restart: got id %0d l%b d%h want 8 1 %h",
                bus.out_wid, bus.out_wlast, bus.out_wdata, SEED);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_narrow();
        test_backpressure();
        test_queue();
        test_full_push_pop();
        test_long_burst();
        test_mid_reset();
        test_errors();
        test_rdy_mode();
        test_srst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_mst_wdata_gen.md
AXI_MST_WDATA_GEN -- requirements
Module: axi_mst_wdata_gen

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 4, the width of AW/W/B IDs.
REQ-002 SHALL have parameter AXI_DATA_W, default 32, the W data width; legal values are powers of 2 from 8 to 256; NB = AXI_DATA_W/8.
REQ-003 SHALL have parameter MST_OSTDREQ_NUM, default 4, the AW request queue depth; it SHALL be a power of 2 and at least 2.
REQ-004 SHALL have parameter LFSR_SEED, default 32'hACE1_2345, the data LFSR reset value; it SHALL be nonzero.
REQ-005 aclk  in  1  sole clock, rising edge.
REQ-006 areset  in  1  asynchronous, active-high reset.
REQ-007 srst  in  1  synchronous clear, active-high; same effect as areset.
REQ-008 in_awvalid, in_awready  in  1 each  observed AW handshake.
REQ-009 in_awid  in  AXI_ID_W  ID of the observed AW request.
REQ-010 in_awlen  in  8  burst length minus 1.
REQ-011 in_awsize  in  3  log2 of bytes per beat.
REQ-012 in_awaddr_lo  in  log2(NB), minimum 1  low address bits giving the start byte lane.
REQ-013 out_wvalid, out_wlast  out  1 each  W channel valid and last.
REQ-014 in_wready  in  1  W channel ready.
REQ-015 out_wid  out  AXI_ID_W  W ID, taken from the head request.
REQ-016 out_wdata  out  AXI_DATA_W  beat data.
REQ-017 out_wstrb  out  NB  beat byte strobes.
REQ-018 in_bvalid  in  1  B channel valid.
REQ-019 in_bid  in  AXI_ID_W  B ID; monitor only.
REQ-020 out_bready, out_rready  out  1 each  response ready signals.
REQ-021 in_rdy_mode  in  2  ready policy: 00 = always 1, 01 = LFSR bit, 10 = always 0, 11 = toggle each cycle.
REQ-022 out_q_full  out  1  request queue full.
REQ-023 out_b_pend  out  8  number of bursts with last beat sent and B not yet received.
REQ-024 out_err  out  3  sticky flags: [0] queue overflow, [1] illegal awsize, [2] unexpected B.

Function
REQ-025 An AW handshake (in_awvalid && in_awready) SHALL push {id, len, size, addr_lo} into the queue, registered.
REQ-026 A W handshake with out_wlast=1 SHALL pop the queue head.
REQ-027 A push when the queue is full SHALL be accepted only if a pop occurs in the same cycle; otherwise the push is dropped and out_err[0] is set.
REQ-028 On a simultaneous push and pop the occupancy count SHALL be unchanged.
REQ-029 Read and write pointers SHALL wrap modulo MST_OSTDREQ_NUM.
REQ-030 out_wvalid SHALL equal (occupancy != 0); the first beat is therefore valid no earlier than one cycle after the AW handshake.
REQ-031 out_wvalid, out_wid, out_wdata, out_wstrb and out_wlast SHALL stay stable while out_wvalid && !in_wready.
REQ-032 The beat counter SHALL be 8 bits, increment on each W handshake, and clear on a handshake with out_wlast=1.
REQ-033 out_wlast SHALL equal out_wvalid && (beat == head len), so bursts of 1 to 256 beats are supported.
REQ-034 If in_awsize > log2(NB), the request SHALL be stored with size log2(NB) and out_err[1] is set.
REQ-035 Strobe rule, with B = 2^size, A0 = addr_lo aligned down to B, and lane = (A0 + beat*B) mod NB:
  - beat 0 strobes bytes [addr_lo .. A0+B-1];
  - beat k>0 strobes bytes [lane .. lane+B-1];
  - all other strobe bits are 0.
REQ-036 The data LFSR SHALL be 32-bit Galois, polynomial x^32+x^22+x^2+x+1, and advance once per W handshake only.
REQ-037 out_wdata SHALL be the LFSR value replicated across AXI_DATA_W, with every byte whose strobe is 0 forced to 0x00.
REQ-038 out_bready and out_rready SHALL be registered and follow in_rdy_mode; the LFSR-bit mode uses LFSR bits 0 and 1 respectively.
REQ-039 out_b_pend SHALL increment on a W-last handshake and decrement on a B handshake; both in one cycle leaves it unchanged; it saturates at 255.
REQ-040 A B handshake while out_b_pend == 0 (with no W-last handshake in the same cycle) SHALL set out_err[2] and leave the count at 0.
REQ-041 out_q_full SHALL equal (occupancy == MST_OSTDREQ_NUM).

Reset
REQ-042 While areset or srst is asserted, the following SHALL be cleared, with no partial burst resumed afterwards:
  - queue, pointers and occupancy;
  - beat counter and out_b_pend;
  - out_err;
  - out_bready and out_rready (to 0).
REQ-043 Under reset the LFSR SHALL load LFSR_SEED.
REQ-044 From reset, outputs SHALL be: out_wvalid=0, out_wlast=0, out_wstrb=0, out_wdata=0, out_wid=0.

Verification
REQ-045 Single request: AW len=3, size=log2(NB), wready=1 -> 4 beats on consecutive cycles, wstrb all ones, wlast only on beat 4, out_b_pend=1.
REQ-046 Narrow, DW=32: AW len=3, size=0, addr_lo=2 -> wstrb 0100, 1000, 0001, 0010, with unstrobed bytes zero.
REQ-047 Backpressure: wready random 50% -> W outputs held stable while stalled; data sequence matches the LFSR reference model.
REQ-048 Queue: push 4 AWs with wready=0, then a 5th -> out_q_full=1, out_err[0]=1; drained bursts are exactly the 4 queued IDs, in order.
REQ-049 Push on the same cycle as the last-beat pop while full -> accepted, no error; 256-beat burst (len=255) -> wlast on beat 256.
REQ-050 Assert areset mid-burst -> all outputs return to reset values immediately; the next AW starts with beat 0 and data = f(LFSR_SEED).
